// File: rtl/pid_controller_v2.sv
// Sample-by-sample PID controller with a clamped integral and a saturated output.
// Multi-cycle FSM: ERR, MUL and SUM stages, then the result is held in OUT until it is taken.
module pid_controller_v2 #(
  parameter int DATA_W = 8,
  parameter int K_W    = 12,
  parameter int FRAC   = 6,
  parameter int ACC_W  = 24,
  parameter int I_LIM  = ((2**DATA_W) - 1) << FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              int_clr,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [K_W-1:0]    cfg_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [DATA_W-1:0] feedback,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] control_out,
  output logic              sat_out,
  output logic              int_sat
);

  localparam int EW = DATA_W + 1;
  localparam int DW = DATA_W + 2;
  localparam int GW = K_W + 1;
  localparam int PW = EW + GW;
  localparam int QW = DW + GW;
  localparam int SW = ACC_W + QW + 2;
  localparam logic signed [SW-1:0] LIM  = SW'(I_LIM);
  localparam logic signed [SW-1:0] OMAX = SW'((2**DATA_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_MUL, S_SUM, S_OUT} state_t;

  state_t                   r_state, w_next;
  logic [K_W-1:0]           r_kp, r_ki, r_kd, r_kp_s, r_ki_s, r_kd_s;
  logic [DATA_W-1:0]        r_sp, r_fb;
  logic signed [EW-1:0]     r_e, r_prev_e, w_e;
  logic signed [DW-1:0]     r_d, w_d;
  logic signed [PW-1:0]     r_p, r_ie;
  logic signed [QW-1:0]     r_dp;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_first;
  logic [DATA_W-1:0]        r_ctrl, w_ctrl;
  logic                     r_sat, r_isat, w_sat, w_isat, w_accept;
  logic signed [SW-1:0]     w_acc_base, w_acc_sum, w_acc_clamp, w_total, w_s;

  assign w_accept    = (r_state == S_IDLE) && en && in_valid;
  assign control_out = r_ctrl;
  assign sat_out     = r_sat;
  assign int_sat     = r_isat;

  assign w_e = $signed({1'b0, r_sp}) - $signed({1'b0, r_fb});
  assign w_d = r_first ? '0 : ({w_e[EW-1], w_e} - {r_prev_e[EW-1], r_prev_e});

  // A clear landing during SUM makes the in-flight sample integrate from zero.
  always_comb begin
    w_acc_base  = int_clr ? '0 : {{(SW-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    w_acc_sum   = w_acc_base + {{(SW-PW){r_ie[PW-1]}}, r_ie};
    w_acc_clamp = w_acc_sum;
    w_isat      = 1'b0;
    if (w_acc_sum > LIM) begin
      w_acc_clamp = LIM;
      w_isat      = 1'b1;
    end else if (w_acc_sum < -LIM) begin
      w_acc_clamp = -LIM;
      w_isat      = 1'b1;
    end
    w_total = {{(SW-PW){r_p[PW-1]}}, r_p} + w_acc_clamp + {{(SW-QW){r_dp[QW-1]}}, r_dp};
    w_s     = w_total >>> FRAC;
    w_ctrl  = w_s[DATA_W-1:0];
    w_sat   = 1'b0;
    if (w_s[SW-1]) begin
      w_ctrl = '0;
      w_sat  = 1'b1;
    end else if (w_s > OMAX) begin
      w_ctrl = '1;
      w_sat  = 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = en;
        if (en && in_valid) w_next = S_ERR;
      end
      S_ERR: w_next = S_MUL;
      S_MUL: w_next = S_SUM;
      S_SUM: w_next = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_kp     <= '0;
      r_ki     <= '0;
      r_kd     <= '0;
      r_kp_s   <= '0;
      r_ki_s   <= '0;
      r_kd_s   <= '0;
      r_sp     <= '0;
      r_fb     <= '0;
      r_e      <= '0;
      r_d      <= '0;
      r_prev_e <= '0;
      r_p      <= '0;
      r_ie     <= '0;
      r_dp     <= '0;
      r_acc    <= '0;
      r_first  <= 1'b1;
      r_ctrl   <= '0;
      r_sat    <= 1'b0;
      r_isat   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (cfg_we) begin
        case (cfg_sel)
          2'd0:    r_kp <= cfg_data;
          2'd1:    r_ki <= cfg_data;
          2'd2:    r_kd <= cfg_data;
          default: ;
        endcase
      end
      if (w_accept) begin
        r_sp   <= setpoint;
        r_fb   <= feedback;
        r_kp_s <= r_kp;
        r_ki_s <= r_ki;
        r_kd_s <= r_kd;
      end
      if (r_state == S_ERR) begin
        r_e <= w_e;
        r_d <= w_d;
      end
      if (r_state == S_MUL) begin
        r_p  <= r_e * $signed({1'b0, r_kp_s});
        r_ie <= r_e * $signed({1'b0, r_ki_s});
        r_dp <= r_d * $signed({1'b0, r_kd_s});
      end
      if (r_state == S_SUM) begin
        r_acc    <= w_acc_clamp[ACC_W-1:0];
        r_prev_e <= r_e;
        r_first  <= 1'b0;
        r_ctrl   <= w_ctrl;
        r_sat    <= w_sat;
        r_isat   <= w_isat;
      end
      if (int_clr) begin
        r_prev_e <= '0;
        r_first  <= 1'b1;
        if (r_state != S_SUM) r_acc <= '0;
      end
    end
  end

endmodule
